filtro_temperatura: RTL

FILTRO_TEMPERATURA -- requirements
Module: filtro_temperatura

---
 rtl/filtro_temperatura_if.sv | 25 ++
 rtl/filtro_temperatura.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/filtro_temperatura_if.sv
// Sample/result bundle between the raw temperature sensor and filtro_temperatura.
// The master drives raw readings; the slave returns the filtered temperature and fault flag.
interface filtro_temperatura_if;
    logic signed [10:0] muestra_in;
    logic               muestra_valida;
    logic signed [10:0] temp_entrada;
    logic               temp_valida;
    logic               sensor_falla;

    modport master (
        output muestra_in,
        output muestra_valida,
        input  temp_entrada,
        input  temp_valida,
        input  sensor_falla
    );

    modport slave (
        input  muestra_in,
        input  muestra_valida,
        output temp_entrada,
        output temp_valida,
        output sensor_falla
    );
endinterface

// File: rtl/filtro_temperatura.sv
// Clamp, 4-sample moving average and no-sample watchdog for a raw temperature sensor.
// Optional spike rejection is built when FILTRO_RECHAZO_PICOS_EN is defined.
module filtro_temperatura #(
    parameter int          LIM_MIN        = -11'sd400,
    parameter int          LIM_MAX        = 32'sd1250,
    parameter int unsigned TIMEOUT_CICLOS = 32'd1000,
    parameter int unsigned UMBRAL_PICO    = 32'd50
) (
    input  logic                 clk,
    input  logic                 rst,
    filtro_temperatura_if.slave  bus
);

    // Readings are 11-bit signed, so limits outside [-1024, 1023] can never bind.
    localparam int LIM_INF = (LIM_MIN < -32'sd1024) ? -32'sd1024 : LIM_MIN;
    localparam int LIM_SUP = (LIM_MAX > 32'sd1023)  ? 32'sd1023  : LIM_MAX;
    localparam logic signed [10:0] LIM_INF_S = 11'(LIM_INF);
    localparam logic signed [10:0] LIM_SUP_S = 11'(LIM_SUP);

    localparam int CW = $clog2(TIMEOUT_CICLOS + 32'd1);
    localparam logic [CW-1:0] CONT_TOPE = CW'(TIMEOUT_CICLOS);
    localparam logic [CW-1:0] CONT_UNO  = CW'(1);
    localparam logic [CW-1:0] CONT_CERO = CW'(0);

    localparam logic signed [10:0] TEMP_RESET = 11'sd200;

    if (TIMEOUT_CICLOS < 32'd1) begin : g_err_timeout
        $error("filtro_temperatura: TIMEOUT_CICLOS must be at least 1");
    end
    if (LIM_INF > LIM_SUP) begin : g_err_limites
        $error("filtro_temperatura: LIM_MIN above LIM_MAX");
    end
    if (UMBRAL_PICO > 32'd2047) begin : g_err_umbral
        $error("filtro_temperatura: UMBRAL_PICO wider than any reading difference");
    end

    typedef enum logic [0:0] {
        ST_VACIA = 1'b0,
        ST_LLENA = 1'b1
    } estado_t;

    function automatic logic signed [10:0] limita(input logic signed [10:0] x);
        if (x < LIM_INF_S) begin
            limita = LIM_INF_S;
        end else if (x > LIM_SUP_S) begin
            limita = LIM_SUP_S;
        end else begin
            limita = x;
        end
    endfunction

    // 13-bit sum, arithmetic shift gives floor toward -infinity.
    function automatic logic signed [10:0] promedio(
        input logic signed [10:0] a,
        input logic signed [10:0] b,
        input logic signed [10:0] c,
        input logic signed [10:0] d
    );
        logic signed [12:0] suma;
        suma = {{2{a[10]}}, a} + {{2{b[10]}}, b} + {{2{c[10]}}, c} + {{2{d[10]}}, d};
        promedio = 11'(suma >>> 2);
    endfunction

    estado_t            estado_r;
    estado_t            estado_sig_s;
    logic signed [10:0] ventana_r [4];
    logic signed [10:0] muestra_lim_s;
    logic signed [10:0] prom_s;
    logic               acepta_s;
    logic               pend_r;
    logic signed [10:0] temp_entrada_r;
    logic               temp_valida_r;
    logic [CW-1:0]      cont_r;
    logic [CW-1:0]      cont_sig_s;
    logic               sensor_falla_r;
    logic               falla_sig_s;
    logic               falla_sube_s;

    assign muestra_lim_s = limita(bus.muestra_in);
    assign prom_s        = promedio(ventana_r[0], ventana_r[1], ventana_r[2], ventana_r[3]);

`ifdef FILTRO_RECHAZO_PICOS_EN
    logic [1:0]         picos_r;
    logic [1:0]         picos_sig_s;
    logic signed [11:0] dif_s;
    logic [11:0]        dif_abs_s;
    logic               es_pico_s;

    // Distance of the clamped reading from the current window average.
    always_comb begin
        dif_s = $signed({muestra_lim_s[10], muestra_lim_s}) - $signed({prom_s[10], prom_s});
        if (dif_s < 12'sd0) begin
            dif_abs_s = 12'(-dif_s);
        end else begin
            dif_abs_s = 12'(dif_s);
        end
        es_pico_s = (dif_abs_s > 12'(UMBRAL_PICO));
    end

    // Accept decision: a third consecutive spike is taken as a genuine step.
    always_comb begin
        acepta_s    = 1'b0;
        picos_sig_s = picos_r;
        if (bus.muestra_valida) begin
            if ((estado_r == ST_LLENA) && es_pico_s) begin
                if (picos_r == 2'd2) begin
                    acepta_s    = 1'b1;
                    picos_sig_s = 2'd0;
                end else begin
                    acepta_s    = 1'b0;
                    picos_sig_s = picos_r + 2'd1;
                end
            end else begin
                acepta_s    = 1'b1;
                picos_sig_s = 2'd0;
            end
        end else begin
            acepta_s = 1'b0;
        end
    end

    // Consecutive-spike counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            picos_r <= 2'd0;
        end else begin
            picos_r <= picos_sig_s;
        end
    end
`else
    // Every valid reading is accepted.
    always_comb begin
        acepta_s = 1'b0;
        if (bus.muestra_valida) begin
            acepta_s = 1'b1;
        end else begin
            acepta_s = 1'b0;
        end
    end
`endif

    // Watchdog: cleared by any valid reading, saturates at the timeout.
    always_comb begin
        cont_sig_s = cont_r;
        if (bus.muestra_valida) begin
            cont_sig_s = CONT_CERO;
        end else if (cont_r == CONT_TOPE) begin
            cont_sig_s = CONT_TOPE;
        end else begin
            cont_sig_s = cont_r + CONT_UNO;
        end
        falla_sig_s  = (cont_sig_s == CONT_TOPE);
        falla_sube_s = falla_sig_s && !sensor_falla_r;
    end

    // Window priming: a fault forgets the history, the next accepted reading refills it.
    always_comb begin
        estado_sig_s = estado_r;
        case (estado_r)
            ST_VACIA: begin
                if (acepta_s) begin
                    estado_sig_s = ST_LLENA;
                end else begin
                    estado_sig_s = ST_VACIA;
                end
            end
            ST_LLENA: begin
                if (falla_sube_s) begin
                    estado_sig_s = ST_VACIA;
                end else begin
                    estado_sig_s = ST_LLENA;
                end
            end
            default: estado_sig_s = ST_VACIA;
        endcase
    end

    // State, watchdog and fault registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_r       <= ST_VACIA;
            cont_r         <= CONT_CERO;
            sensor_falla_r <= 1'b0;
        end else begin
            estado_r       <= estado_sig_s;
            cont_r         <= cont_sig_s;
            sensor_falla_r <= falla_sig_s;
        end
    end

    // Sample window; ventana_r[0] is the newest entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                ventana_r[i] <= 11'sd0;
            end
        end else if (acepta_s) begin
            if (estado_r == ST_VACIA) begin
                for (int i = 0; i < 4; i++) begin
                    ventana_r[i] <= muestra_lim_s;
                end
            end else begin
                ventana_r[3] <= ventana_r[2];
                ventana_r[2] <= ventana_r[1];
                ventana_r[1] <= ventana_r[0];
                ventana_r[0] <= muestra_lim_s;
            end
        end
    end

    // Result publishes one edge after the window update.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_r         <= 1'b0;
            temp_valida_r  <= 1'b0;
            temp_entrada_r <= TEMP_RESET;
        end else begin
            pend_r        <= acepta_s;
            temp_valida_r <= pend_r;
            if (pend_r) begin
                temp_entrada_r <= prom_s;
            end
        end
    end

    assign bus.temp_entrada = temp_entrada_r;
    assign bus.temp_valida  = temp_valida_r;
    assign bus.sensor_falla = sensor_falla_r;

endmodule
